pe_window_feeder: RTL

Operand transmitter for the 9-cell processing element. Accepts a raster-order 8-bit pixel stream over a valid/ready handshake and buffers two prior rows in line buffers. Emits one 3×3 window per cycle on the PE's `in`/`en` interface, and holds the weight, bias, step and bound_level operands the PE samples alongside. Sits directly upstream of one PE; the PE never back-pressures, so windows are emitted the cycle after they complete.

---
 rtl/pe_feeder_pkg.sv | 15 +
 rtl/pe_line_buffer.sv | 22 ++
 rtl/pe_window_feeder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pe_feeder_pkg.sv
// rtl/pe_feeder_pkg.sv - shared widths and FSM encoding for the PE window feeder
package pe_feeder_pkg;

  localparam int CELL_BIT = 8;
  localparam int N_CELL   = 9;
  localparam int BIAS_W   = 16;
  localparam int WIN_W    = CELL_BIT * N_CELL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/pe_line_buffer.sv
// rtl/pe_line_buffer.sv - one-row pixel delay indexed by column, read-before-write
module pe_line_buffer #(
  parameter int DEPTH = 256,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Asynchronous read returns the previous row's pixel before this cycle's write lands.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/pe_window_feeder.sv
// rtl/pe_window_feeder.sv - raster stream to 3x3 window operand feeder for one PE
// Optional PE_FEEDER_STRIDE2_EN adds a stride2 input that keeps only even-aligned windows.
module pe_window_feeder
  import pe_feeder_pkg::*;
#(
  parameter int MAX_W  = 256,
  parameter int W_BITS = 9,
  parameter int H_BITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [W_BITS-1:0]   img_w,
  input  logic [H_BITS-1:0]   img_h,
  input  logic [2:0]          cfg_step,
  input  logic [2:0]          cfg_bound,
`ifdef PE_FEEDER_STRIDE2_EN
  input  logic                stride2,
`endif
  input  logic                wt_load,
  input  logic [WIN_W-1:0]    wt_data,
  input  logic [BIAS_W-1:0]   bias_data,
  input  logic [CELL_BIT-1:0] pix,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [WIN_W-1:0]    win,
  output logic [WIN_W-1:0]    weight,
  output logic [BIAS_W-1:0]   bias,
  output logic [2:0]          step,
  output logic [2:0]          bound_level,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int AW = $clog2(MAX_W);

  feeder_state_t       state_q, state_d;
  logic [W_BITS-1:0]   img_w_q, col_q;
  logic [H_BITS-1:0]   img_h_q, row_q;
  logic                start_ok, cfg_err_d, geom_ok;
  logic                accept, last_pix, win_fire, stride_ok;
  logic [CELL_BIT-1:0] lb0_rd, lb1_rd;
  logic [CELL_BIT-1:0] sr_q [N_CELL];
  logic [CELL_BIT-1:0] sr_d [N_CELL];
  logic [WIN_W-1:0]    win_d;

  assign geom_ok  = (img_w >= W_BITS'(3)) && (img_w <= W_BITS'(MAX_W)) && (img_h >= H_BITS'(3));
  assign accept   = (state_q == RUN) && pix_valid;
  assign last_pix = accept && (row_q == img_h_q - H_BITS'(1)) && (col_q == img_w_q - W_BITS'(1));

`ifdef PE_FEEDER_STRIDE2_EN
  logic stride_q;
  // Top-left (r-2, c-2) is even exactly when r and c are even.
  assign stride_ok = !stride_q || (!row_q[0] && !col_q[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        stride_q <= 1'b0;
    else if (start_ok) stride_q <= stride2;
  end
`else
  assign stride_ok = 1'b1;
`endif

  assign win_fire = accept && (row_q >= H_BITS'(2)) && (col_q >= W_BITS'(2)) && stride_ok;

  pe_line_buffer #(.DEPTH(MAX_W), .DW(CELL_BIT)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q[AW-1:0]),
    .wdata (pix),
    .rdata (lb0_rd)
  );

  pe_line_buffer #(.DEPTH(MAX_W), .DW(CELL_BIT)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q[AW-1:0]),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Each window row shifts left; new right column is row r-2, r-1, r from top to bottom.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sr_d[3*r]     = sr_q[3*r+1];
      sr_d[3*r + 1] = sr_q[3*r+2];
      sr_d[3*r + 2] = sr_q[3*r+2];
    end
    sr_d[2] = lb1_rd;
    sr_d[5] = lb0_rd;
    sr_d[8] = pix;
    win_d   = '0;
    for (int k = 0; k < N_CELL; k++) win_d[CELL_BIT*k +: CELL_BIT] = sr_d[k];
  end

  always_ff @(posedge clk) begin
    if (accept) sr_q <= sr_d;
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    cfg_err_d = 1'b0;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (geom_ok) begin
            state_d  = RUN;
            start_ok = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (last_pix) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      img_w_q     <= '0;
      img_h_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win         <= '0;
      en          <= 1'b0;
      weight      <= '0;
      bias        <= '0;
      step        <= '0;
      bound_level <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_err <= cfg_err_d;
      en      <= win_fire;
      if (win_fire) win <= win_d;
      if (start_ok) begin
        img_w_q     <= img_w;
        img_h_q     <= img_h;
        step        <= cfg_step;
        bound_level <= cfg_bound;
        col_q       <= '0;
        row_q       <= '0;
      end else if (accept) begin
        if (col_q == img_w_q - W_BITS'(1)) begin
          col_q <= '0;
          row_q <= row_q + H_BITS'(1);
        end else begin
          col_q <= col_q + W_BITS'(1);
        end
      end
      if (wt_load && (state_q == IDLE)) begin
        weight <= wt_data;
        bias   <= bias_data;
      end
    end
  end

endmodule
